instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute/writeback controller for the 8-bit processor datapath.
//  Owns the PC, fetches 32-bit instructions over a req/ack handshake, and drives the controls below:
//  regfile addresses and write enable, ALU select, immediate mux and add/sub (two's complement) mux.
//  Sits between instruction memory and the regfile/ALU.
//  Replaces the free-running counter and the combinational decode.
// PARAMETERS
//  PC_WIDTH       32  PC / imem address width
//  PC_STEP        4   PC increment per instruction (byte addressed)
//  RESET_PC       0   PC value loaded at reset
//  FETCH_TIMEOUT  15  max cycles FETCH waits for imem_ack before ERROR (1..255)
// PORTS
//  clk          in   1         clock, all state updates on posedge
//  reset        in   1         asynchronous, active-low reset
//  start        in   1         leave IDLE and begin fetching at current PC
//  imem_req     out  1         fetch request, held until ack
//  imem_addr    out  PC_WIDTH  fetch address (= PC)
//  imem_ack     in   1         fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32        instruction word
//  out1addr     out  3         regfile read port 1 address (instr[2:0])
//  out2addr     out  3         regfile read port 2 address (instr[10:8])
//  inaddr       out  3         regfile write address (instr[18:16])
//  rf_we        out  1         regfile write enable, one-cycle pulse in WB
//  alu_select   out  3         000 fwd, 001 add, 010 and, 011 or
//  imm_value    out  8         immediate (instr[7:0])
//  imm_sel      out  1         1: ALU DATA1 = imm_value
//  sub_sel      out  1         1: ALU DATA2 = two's complement of OUT2
//  alu_zero     in   1         ALU result == 0 (BRANCH_EN only)
//  busy         out  1         high in any state except IDLE/HALT/ERROR
//  halted       out  1         high in HALT
//  error        out  2         00 none, 01 illegal opcode, 10 fetch timeout
// BEHAVIOUR
//  Reset (reset==0, immediate, any state):
//   - state=IDLE, PC=RESET_PC, IR=0, timeout counter=0.
//   - All outputs 0, except imem_addr=RESET_PC.
//  Opcode instr[31:24]:
//   - 00 loadi (imm->dest), 01 mov, 02 add, 03 sub, 04 and, 05 or, FF halt.
//   - Any other value is illegal.
//  FSM:
//   - IDLE: start=1 -> FETCH. start is ignored in all other states.
//   - FETCH: imem_req=1, imem_addr=PC stable until ack.
//     - ack=1: IR<=imem_rdata -> DECODE.
//     - Else counter++; counter==FETCH_TIMEOUT -> ERROR, error=10.
//     - Ack in the timeout cycle wins (goes to DECODE). Counter clears on FETCH entry.
//   - DECODE (1 cycle): out1addr/out2addr/inaddr/imm_value driven from IR; regfile reads on this edge.
//     - Illegal opcode -> ERROR, error=01.
//     - FF -> HALT.
//   - EXEC (1 cycle): alu_select/imm_sel/sub_sel valid.
//     - loadi: sel=000, imm_sel=1. mov: 000. add: 001. sub: 001, sub_sel=1. and: 010. or: 011.
//   - WB (1 cycle): rf_we=1, controls held from EXEC; PC<=PC+PC_STEP -> FETCH.
//   - HALT, ERROR: sticky until reset. No imem_req, no rf_we.
//  Register addresses, alu_select, imm_value, imm_sel and sub_sel hold from DECODE through WB.
//  Outside DECODE..WB they drive 0.
//  Latency: 4 cycles/instruction with zero-wait ack (FETCH, DECODE, EXEC, WB).
//  PC arithmetic is modulo 2^PC_WIDTH; the wrap from max to 0 is silent.
// CONFIGURATION
//  BRANCH_EN defined:
//   - Adds opcodes 06 j and 07 beq.
//   - j: PC<=PC+PC_STEP+PC_STEP*sext(instr[23:16]).
//   - beq: EXEC uses alu_select=001, sub_sel=1 on out1addr/out2addr. alu_zero==1 takes the same
//     target, else PC+PC_STEP.
//   - Branches skip WB (rf_we stays 0); EXEC -> FETCH directly, 3 cycles.
//  BRANCH_EN undefined: 06/07 are illegal (error=01); the alu_zero input is ignored.
// TESTING
//  Reset + start, ack same cycle, IR=0x00_02_00_05 -> 4 cycles; WB has rf_we=1, inaddr=2,
//   imm_sel=1; PC=4.
//  sub r1=r3-r2 (0x03_01_02_03), ack after 3 wait cycles -> sub_sel=1, alu_select=001, rf_we one
//   cycle; busy high throughout.
//  No ack for 15 FETCH cycles -> ERROR, error=10, imem_req low.
//  Ack on the 15th cycle -> DECODE, no error.
//  Opcode 0x09 -> ERROR, error=01, rf_we never asserted. Opcode 0xFF -> halted=1, start ignored.
//  reset low mid-EXEC -> same cycle: rf_we=0, busy=0, PC=RESET_PC, no writeback after release.
//  BRANCH_EN: beq with alu_zero=1, offset 0xFE at PC=8 -> PC=4; with alu_zero=0 -> PC=12.
//   PC=0xFFFFFFFC add -> PC=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and instruction memory (slave).
// The request/address pair is held by the master until the slave acknowledges.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback controller for the 8-bit datapath: owns the PC and drives regfile/ALU controls.
// Optional macro BRANCH_EN adds opcodes 06 (j) and 07 (beq); without it they are illegal.
module instr_sequencer #(
  parameter int                  PC_WIDTH      = 32,
  parameter int                  PC_STEP       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter int                  FETCH_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  instr_sequencer_if.master        imem,
  output logic [2:0]               out1addr,
  output logic [2:0]               out2addr,
  output logic [2:0]               inaddr,
  output logic                     rf_we,
  output logic [2:0]               alu_select,
  output logic [7:0]               imm_value,
  output logic                     imm_sel,
  output logic                     sub_sel,
  input  logic                     alu_zero,
  output logic                     busy,
  output logic                     halted,
  output logic [1:0]               error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
`ifdef BRANCH_EN
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
`endif
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [PC_WIDTH-1:0] STEP         = PC_WIDTH'(PC_STEP);
  localparam logic [7:0]          TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [2:0]          state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]         ir_reg, ir_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [1:0]          err_reg, err_next;

  logic [7:0]          opcode;
  logic                op_legal;
  logic                op_halt;
  logic [2:0]          dec_alu;
  logic                dec_imm;
  logic                dec_sub;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                ctrl_active;

`ifdef BRANCH_EN
  logic                op_branch;
  logic                op_beq;
  logic [PC_WIDTH-1:0] br_sext;
  logic [PC_WIDTH-1:0] br_target;
  logic                br_taken;
`endif

  assign opcode = ir_reg[31:24];
  assign pc_inc = pc_reg + STEP;

  always_comb begin
    op_legal = 1'b1;
    op_halt  = 1'b0;
    dec_alu  = ALU_FWD;
    dec_imm  = 1'b0;
    dec_sub  = 1'b0;
`ifdef BRANCH_EN
    op_branch = 1'b0;
    op_beq    = 1'b0;
`endif
    case (opcode)
      OP_LOADI: dec_imm = 1'b1;
      OP_MOV:   dec_alu = ALU_FWD;
      OP_ADD:   dec_alu = ALU_ADD;
      OP_SUB: begin
        dec_alu = ALU_ADD;
        dec_sub = 1'b1;
      end
      OP_AND:   dec_alu = ALU_AND;
      OP_OR:    dec_alu = ALU_OR;
      OP_HALT:  op_halt = 1'b1;
`ifdef BRANCH_EN
      OP_J:     op_branch = 1'b1;
      // beq compares by subtracting the two register operands in the ALU
      OP_BEQ: begin
        op_branch = 1'b1;
        op_beq    = 1'b1;
        dec_alu   = ALU_ADD;
        dec_sub   = 1'b1;
      end
`endif
      default:  op_legal = 1'b0;
    endcase
  end

`ifdef BRANCH_EN
  // Offset is in instructions; the multiply is truncated, so wrap is modulo 2^PC_WIDTH
  assign br_sext   = {{(PC_WIDTH-8){ir_reg[23]}}, ir_reg[23:16]};
  assign br_target = pc_inc + (br_sext * STEP);
  assign br_taken  = !op_beq || alu_zero;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          cnt_next   = '0;
        end
      end
      S_FETCH: begin
        // An ack arriving in the last allowed cycle still wins over the timeout
        if (imem.imem_ack) begin
          ir_next    = imem.imem_rdata;
          state_next = S_DECODE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == TIMEOUT_LAST) begin
            state_next = S_ERROR;
            err_next   = ERR_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (!op_legal) begin
          state_next = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end else if (op_halt) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
`ifdef BRANCH_EN
        if (op_branch) begin
          pc_next    = br_taken ? br_target : pc_inc;
          state_next = S_FETCH;
          cnt_next   = '0;
        end else begin
          state_next = S_WB;
        end
`else
        state_next = S_WB;
`endif
      end
      S_WB: begin
        pc_next    = pc_inc;
        state_next = S_FETCH;
        cnt_next   = '0;
      end
      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      cnt_reg   <= '0;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Datapath controls are only meaningful while an instruction is in flight
  assign ctrl_active = (state_reg == S_DECODE) || (state_reg == S_EXEC) || (state_reg == S_WB);

  assign out1addr   = ctrl_active ? ir_reg[2:0]   : 3'b000;
  assign out2addr   = ctrl_active ? ir_reg[10:8]  : 3'b000;
  assign inaddr     = ctrl_active ? ir_reg[18:16] : 3'b000;
  assign imm_value  = ctrl_active ? ir_reg[7:0]   : 8'h00;
  assign alu_select = ctrl_active ? dec_alu       : ALU_FWD;
  assign imm_sel    = ctrl_active && dec_imm;
  assign sub_sel    = ctrl_active && dec_sub;

  assign rf_we  = (state_reg == S_WB);
  assign busy   = (state_reg == S_FETCH) || ctrl_active;
  assign halted = (state_reg == S_HALT);
  assign error  = err_reg;

  assign imem.imem_req  = (state_reg == S_FETCH);
  assign imem.imem_addr = pc_reg;

  // Instruction bits with no decoded meaning, plus alu_zero when branches are compiled out
  logic unused_bits;
`ifdef BRANCH_EN
  assign unused_bits = ^{ir_reg[15:11]};
`else
  assign unused_bits = ^{alu_zero, ir_reg[23:19], ir_reg[15:11]};
`endif

endmodule
